// File: rtl/sonic_echo_responder_if.sv
// -----------------------------------------------------------------------------
// sonic_echo_responder_if
//
// Trig/echo signal bundle between a sonar ranging controller (master) and the
// ultrasonic sensor emulator (slave).
//
//   trig         master -> slave  trigger pulse, asynchronous to the slave clock
//   distance_cm  master -> slave  emulated distance in cm (9 bits)
//   obj_present  master -> slave  1 = object in range, 0 = force timeout echo
//   echo         slave -> master  echo pulse, width encodes distance
//   busy         slave -> master  responder is servicing a trigger
//   trig_err     slave -> master  one-cycle pulse: trig was too short
// -----------------------------------------------------------------------------
interface sonic_echo_responder_if;
  logic       trig;
  logic [8:0] distance_cm;
  logic       obj_present;
  logic       echo;
  logic       busy;
  logic       trig_err;

  modport master (
    output trig, distance_cm, obj_present,
    input  echo, busy, trig_err
  );

  modport slave (
    input  trig, distance_cm, obj_present,
    output echo, busy, trig_err
  );
endinterface

// File: rtl/sonic_echo_responder.sv
// -----------------------------------------------------------------------------
// sonic_echo_responder
//
// Emulates an ultrasonic ranging sensor. A sufficiently long trigger pulse is
// accepted on its falling edge. After a fixed burst delay the block drives an
// echo pulse whose width is the programmed distance times US_PER_CM. If there
// is no object, or the distance is out of range, the echo lasts TIMEOUT_US
// instead. A holdoff period follows, during which triggers are ignored.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    sonic_echo_responder_if.slave
//            in : trig (async), distance_cm, obj_present
//            out: echo, busy, trig_err (all registered)
// -----------------------------------------------------------------------------
module sonic_echo_responder #(
  parameter int unsigned CLK_PER_US  = 100,
  parameter int unsigned TRIG_MIN_US = 10,
  parameter int unsigned BURST_US    = 200,
  parameter int unsigned US_PER_CM   = 58,
  parameter int unsigned MAX_CM      = 400,
  parameter int unsigned TIMEOUT_US  = 38000,
  parameter int unsigned HOLDOFF_US  = 1000
) (
  input logic                   clk,
  input logic                   rst_n,
  sonic_echo_responder_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  localparam logic [PW-1:0] PRESC_LAST   = PW'(CLK_PER_US - 1);
  localparam logic [15:0]   TRIG_MIN_CYC = 16'(TRIG_MIN_US * CLK_PER_US);
  localparam logic [15:0]   BURST_US_W   = 16'(BURST_US);
  localparam logic [15:0]   HOLDOFF_US_W = 16'(HOLDOFF_US);
  localparam logic [15:0]   TIMEOUT_US_W = 16'(TIMEOUT_US);
  localparam logic [15:0]   US_PER_CM_W  = 16'(US_PER_CM);
  localparam logic [15:0]   MAX_CM_W     = 16'(MAX_CM);
  localparam logic [15:0]   MIN_CM_W     = 16'd2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIG_HI = 3'd1;
  localparam logic [2:0] ST_BURST   = 3'd2;
  localparam logic [2:0] ST_ECHO    = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  // ---------------------------------------------------------------------------
  // Trigger synchronizer and edge detect
  // ---------------------------------------------------------------------------
  logic trig_meta_q;
  logic trig_s_q;
  logic trig_prev_q;
  logic trig_rise;
  logic trig_fall;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours; a blocking
  // assignment here would collapse the two synchronizer stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_meta_q <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_meta_q <= bus.trig;
      trig_s_q    <= trig_meta_q;
      trig_prev_q <= trig_s_q;
    end
  end

  assign trig_rise = trig_s_q & ~trig_prev_q;
  assign trig_fall = ~trig_s_q & trig_prev_q;

  // ---------------------------------------------------------------------------
  // State, timers and outputs
  // ---------------------------------------------------------------------------
  logic [2:0]    state_q,   state_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic [15:0]   us_q,      us_d;
  logic [15:0]   width_q,   width_d;    // trig high width in cycles
  logic [15:0]   echo_w_q,  echo_w_d;   // latched echo width in us
  logic          echo_q,    echo_d;
  logic          busy_q,    busy_d;
  logic          trig_err_q, trig_err_d;

  // ---------------------------------------------------------------------------
  // Echo width from the live distance inputs; only latched on acceptance, so
  // later input changes never reach a pulse already in flight.
  // ---------------------------------------------------------------------------
  logic [15:0] dist_ext;
  logic [15:0] dist_clamped;
  logic [15:0] echo_w_new;

  always_comb begin
    dist_ext     = {7'd0, bus.distance_cm};
    dist_clamped = (dist_ext < MIN_CM_W) ? MIN_CM_W : dist_ext;
    if (!bus.obj_present || (dist_ext > MAX_CM_W)) begin
      echo_w_new = TIMEOUT_US_W;
    end else begin
      echo_w_new = dist_clamped * US_PER_CM_W;
    end
  end

  // ---------------------------------------------------------------------------
  // Interval timer: prescaler counts cycles within a microsecond, us_q counts
  // whole microseconds. interval_done is high in the last cycle of an interval
  // of interval_us microseconds measured from state entry.
  // ---------------------------------------------------------------------------
  logic [15:0] interval_us;
  logic        presc_last;
  logic        interval_done;

  always_comb begin
    unique case (state_q)
      ST_BURST:   interval_us = BURST_US_W;
      ST_ECHO:    interval_us = echo_w_q;
      ST_HOLDOFF: interval_us = HOLDOFF_US_W;
      default:    interval_us = 16'd0;
    endcase
  end

  assign presc_last    = (presc_q == PRESC_LAST);
  assign interval_done = presc_last && (us_q == (interval_us - 16'd1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    echo_w_d   = echo_w_q;
    echo_d     = echo_q;
    busy_d     = busy_q;
    trig_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (trig_rise) begin
          // The rise-detect cycle is the first high cycle of the pulse.
          state_d = ST_TRIG_HI;
          width_d = 16'd1;
        end
      end

      ST_TRIG_HI: begin
        if (trig_fall) begin
          if (width_q >= TRIG_MIN_CYC) begin
            state_d  = ST_BURST;
            echo_w_d = echo_w_new;
            busy_d   = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            trig_err_d = 1'b1;
          end
        end else if (width_q != 16'hFFFF) begin
          width_d = width_q + 16'd1;
        end
      end

      ST_BURST: begin
        if (interval_done) begin
          state_d = ST_ECHO;
          echo_d  = 1'b1;
        end
      end

      ST_ECHO: begin
        if (interval_done) begin
          state_d = ST_HOLDOFF;
          echo_d  = 1'b0;
        end
      end

      ST_HOLDOFF: begin
        if (interval_done) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        echo_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Timers restart on every state change so each interval is exact.
  always_comb begin
    if (state_d != state_q) begin
      presc_d = '0;
      us_d    = 16'd0;
    end else if (presc_last) begin
      presc_d = '0;
      us_d    = us_q + 16'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      us_d    = us_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      us_q       <= 16'd0;
      width_q    <= 16'd0;
      echo_w_q   <= 16'd0;
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
      trig_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      us_q       <= us_d;
      width_q    <= width_d;
      echo_w_q   <= echo_w_d;
      echo_q     <= echo_d;
      busy_q     <= busy_d;
      trig_err_q <= trig_err_d;
    end
  end

  assign bus.echo     = echo_q;
  assign bus.busy     = busy_q;
  assign bus.trig_err = trig_err_q;

endmodule

// File: tb/tb_sonic_echo_responder.sv
// -----------------------------------------------------------------------------
// tb_sonic_echo_responder
//
// Directed bench for sonic_echo_responder with scaled-down timing parameters:
//   CLK_PER_US=2, TRIG_MIN_US=10 (20 cycles), BURST_US=20 (40 cycles),
//   US_PER_CM=3, MAX_CM=400, TIMEOUT_US=1500 (3000 cycles),
//   HOLDOFF_US=50 (100 cycles).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sonic_echo_responder;

  localparam int C_PER_US  = 2;
  localparam int LAT       = 2 + 20 * C_PER_US + 1; // negedges from trig drop to echo seen
  localparam int BUSY_LAT  = 3;                     // negedges from trig drop to busy seen
  localparam int HOLD_CYC  = 50 * C_PER_US;
  localparam int W100_CYC  = 100 * 3 * C_PER_US;    // 100 cm -> 300 us -> 600 cycles
  localparam int BUDGET    = 10000;

  logic clk;
  logic rst_n;

  sonic_echo_responder_if bus ();

  sonic_echo_responder #(
    .CLK_PER_US (2),
    .TRIG_MIN_US(10),
    .BURST_US   (20),
    .US_PER_CM  (3),
    .MAX_CM     (400),
    .TIMEOUT_US (1500),
    .HOLDOFF_US (50)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Event monitors
  int   err_cnt    = 0;
  int   busy_cyc   = 0;
  int   echo_rises = 0;
  logic echo_prev  = 1'b0;

  always @(negedge clk) begin
    if (bus.trig_err === 1'b1) err_cnt++;
    if (bus.busy === 1'b1) busy_cyc++;
    if (bus.echo === 1'b1 && echo_prev !== 1'b1) echo_rises++;
    echo_prev = bus.echo;
  end

  // Hard time limit as a backstop; every wait below is also cycle-bounded.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // trig is sampled high at exactly h rising edges.
  task automatic pulse_trig(input int h);
    @(negedge clk);
    bus.trig = 1'b1;
    repeat (h) @(negedge clk);
    bus.trig = 1'b0;
  endtask

  // Called right after trig is dropped. Reports negedges until busy and echo
  // are first seen, echo high width, and busy tail after echo falls.
  task automatic measure(output int lat, output int blat, output int w, output int h);
    lat  = 0;
    blat = 0;
    w    = 0;
    h    = 0;
    while (bus.echo !== 1'b1 && lat < BUDGET) begin
      @(negedge clk);
      lat++;
      if (bus.busy === 1'b1 && blat == 0) blat = lat;
    end
    while (bus.echo === 1'b1 && w < BUDGET) begin
      w++;
      @(negedge clk);
    end
    while (bus.busy === 1'b1 && h < BUDGET) begin
      @(negedge clk);
      h++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n           = 1'b0;
    bus.trig        = 1'b0;
    bus.distance_cm = 9'd100;
    bus.obj_present = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.echo !== 1'b0) begin n_fail++; $display("FAIL reset_echo: got %b want 0", bus.echo); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.trig_err !== 1'b0) begin n_fail++; $display("FAIL reset_trig_err: got %b want 0", bus.trig_err); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.echo !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b echo=%b want 0 0", bus.busy, bus.echo);
    end
  endtask

  task automatic test_nominal();
    int lat, blat, w, h, e0;
    e0 = err_cnt;
    bus.distance_cm = 9'd100;
    bus.obj_present = 1'b1;
    pulse_trig(24);
    measure(lat, blat, w, h);
    n_checks++; if (blat !== BUSY_LAT) begin n_fail++; $display("FAIL nominal_busy_rise: got %0d want %0d", blat, BUSY_LAT); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL nominal_echo_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (w !== W100_CYC) begin n_fail++; $display("FAIL nominal_echo_width: got %0d want %0d", w, W100_CYC); end
    n_checks++; if (h !== HOLD_CYC) begin n_fail++; $display("FAIL nominal_holdoff: got %0d want %0d", h, HOLD_CYC); end
    n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL nominal_no_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_width_rules();
    int   dist_tab [6] = '{0, 1, 2, 400, 401, 100};
    logic obj_tab  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   exp_tab  [6] = '{12, 12, 12, 2400, 3000, 3000};
    int lat, blat, w, h;
    for (int i = 0; i < 6; i++) begin
      bus.distance_cm = 9'(dist_tab[i]);
      bus.obj_present = obj_tab[i];
      pulse_trig(24);
      measure(lat, blat, w, h);
      n_checks++; if (w !== exp_tab[i]) begin
        n_fail++; $display("FAIL width_rule dist=%0d obj=%b: got %0d want %0d", dist_tab[i], obj_tab[i], w, exp_tab[i]);
      end
      n_checks++; if (lat !== LAT) begin
        n_fail++; $display("FAIL width_rule_latency dist=%0d: got %0d want %0d", dist_tab[i], lat, LAT);
      end
    end
    bus.distance_cm = 9'd100;
    bus.obj_present = 1'b1;
  endtask

  task automatic test_trig_min();
    int lat, blat, w, h, e0, b0, r0;
    e0 = err_cnt;
    b0 = busy_cyc;
    r0 = echo_rises;
    pulse_trig(19);
    repeat (100) @(negedge clk);
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL short_trig_err_cycles: got %0d want 1", err_cnt - e0); end
    n_checks++; if (busy_cyc !== b0) begin n_fail++; $display("FAIL short_trig_busy: got %0d busy cycles want 0", busy_cyc - b0); end
    n_checks++; if (echo_rises !== r0) begin n_fail++; $display("FAIL short_trig_echo: got %0d echoes want 0", echo_rises - r0); end
    pulse_trig(20);
    measure(lat, blat, w, h);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL min_trig_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (w !== W100_CYC) begin n_fail++; $display("FAIL min_trig_width: got %0d want %0d", w, W100_CYC); end
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL min_trig_no_err: got %0d err cycles want 1", err_cnt - e0); end
  endtask

  task automatic test_retrigger();
    int lat, blat, w, h, e0, b0, r0, cnt;
    e0 = err_cnt;
    r0 = echo_rises;
    pulse_trig(24);
    cnt = 0;
    while (bus.echo !== 1'b1 && cnt < BUDGET) begin
      @(negedge clk);
      cnt++;
    end
    // Retrigger inside ECHO.
    w = 0;
    while (bus.echo === 1'b1 && w < BUDGET) begin
      w++;
      if (w == 20) bus.trig = 1'b1;
      if (w == 44) bus.trig = 1'b0;
      @(negedge clk);
    end
    // Retrigger inside HOLDOFF, then a trig that is still high as HOLDOFF ends.
    h = 0;
    while (bus.busy === 1'b1 && h < BUDGET) begin
      if (h == 10) bus.trig = 1'b1;
      if (h == 34) bus.trig = 1'b0;
      if (h == 90) bus.trig = 1'b1;
      @(negedge clk);
      h++;
    end
    b0 = busy_cyc;
    repeat (50) @(negedge clk);
    bus.trig = 1'b0;
    repeat (60) @(negedge clk);
    n_checks++; if (w !== W100_CYC) begin n_fail++; $display("FAIL retrig_echo_width: got %0d want %0d", w, W100_CYC); end
    n_checks++; if (h !== HOLD_CYC) begin n_fail++; $display("FAIL retrig_holdoff: got %0d want %0d", h, HOLD_CYC); end
    n_checks++; if (echo_rises - r0 !== 1) begin n_fail++; $display("FAIL retrig_echo_count: got %0d want 1", echo_rises - r0); end
    n_checks++; if (busy_cyc !== b0) begin n_fail++; $display("FAIL held_trig_accepted: got %0d busy cycles want 0", busy_cyc - b0); end
    n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL retrig_err: got %0d want 0", err_cnt - e0); end
    // Fresh trigger after busy has fallen is serviced normally.
    pulse_trig(24);
    measure(lat, blat, w, h);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL back_to_back_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (w !== W100_CYC) begin n_fail++; $display("FAIL back_to_back_width: got %0d want %0d", w, W100_CYC); end
  endtask

  task automatic test_dist_change();
    int lat, blat, w, h;
    bus.distance_cm = 9'd100;
    bus.obj_present = 1'b1;
    pulse_trig(24);
    repeat (10) @(negedge clk);
    bus.distance_cm = 9'd300;
    bus.obj_present = 1'b0;
    measure(lat, blat, w, h);
    n_checks++; if (lat !== LAT - 10) begin n_fail++; $display("FAIL dist_change_latency: got %0d want %0d", lat, LAT - 10); end
    n_checks++; if (w !== W100_CYC) begin n_fail++; $display("FAIL dist_change_width: got %0d want %0d", w, W100_CYC); end
    bus.distance_cm = 9'd100;
    bus.obj_present = 1'b1;
  endtask

  task automatic test_reset_mid();
    int lat, blat, w, h, e0, cnt;
    bus.distance_cm = 9'd100;
    bus.obj_present = 1'b1;
    pulse_trig(24);
    cnt = 0;
    while (bus.echo !== 1'b1 && cnt < BUDGET) begin
      @(negedge clk);
      cnt++;
    end
    repeat (50) @(negedge clk);
    n_checks++; if (bus.echo !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_active: echo=%b busy=%b want 1 1", bus.echo, bus.busy);
    end
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    bus.trig = 1'b1;
    #1;
    n_checks++; if (bus.echo !== 1'b0) begin n_fail++; $display("FAIL mid_reset_echo: got %b want 0", bus.echo); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", bus.busy); end
    repeat (3) @(negedge clk);
    e0    = err_cnt;
    rst_n = 1'b1;
    // trig already high at release: width counts from release, 20 cycles accepted.
    repeat (20) @(negedge clk);
    bus.trig = 1'b0;
    measure(lat, blat, w, h);
    n_checks++; if (blat !== BUSY_LAT) begin n_fail++; $display("FAIL post_reset_busy_rise: got %0d want %0d", blat, BUSY_LAT); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL post_reset_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (w !== W100_CYC) begin n_fail++; $display("FAIL post_reset_width: got %0d want %0d", w, W100_CYC); end
    n_checks++; if (h !== HOLD_CYC) begin n_fail++; $display("FAIL post_reset_holdoff: got %0d want %0d", h, HOLD_CYC); end
    n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL post_reset_err: got %0d want 0", err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_width_rules();
    test_trig_min();
    test_retrigger();
    test_dist_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sonic_echo_responder.md
Name: sonic_echo_responder

Overview:
- Emulates the ultrasonic ranging module at the far end of the trig/echo interface. It is the responder to the car's sonar initiator.
- Accepts a trigger pulse from the ranging controller, waits a fixed burst delay, then drives an echo pulse whose width encodes a programmed distance.
- Used for hardware-in-loop bring-up on the board and as the bench model for the sonar path. It lets stop-distance logic be exercised without the physical sensor.

Parameters:
- CLK_PER_US, 100, clock cycles per microsecond (100 MHz clk).
- TRIG_MIN_US, 10, minimum accepted trig high width, us.
- BURST_US, 200, delay from accepted trig fall to echo rise, us.
- US_PER_CM, 58, echo width per cm of distance, us.
- MAX_CM, 400, largest reportable distance, cm.
- TIMEOUT_US, 38000, echo width when no object / out of range, us.
- HOLDOFF_US, 1000, dead time after echo fall during which trig is ignored, us.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- trig  in  1  trigger from ranging controller, asynchronous to clk
- distance_cm  in  9  emulated distance, sampled at trig acceptance
- obj_present  in  1  1 = object in range; 0 = force timeout echo
- echo  out  1  echo pulse to ranging controller, registered
- busy  out  1  high from trig acceptance until end of holdoff, registered
- trig_err  out  1  one-cycle pulse: trig high too short, registered

Behaviour:
- Reset (async, rst_n=0): state IDLE; echo=0, busy=0, trig_err=0; synchronizer flops=0; all counters=0; latched width=0.
- trig passes through a 2-flop synchronizer giving trig_s. Edges are detected against a registered copy of trig_s.
- Timing uses a cycle prescaler (0..CLK_PER_US-1) plus a 16-bit us counter. Both clear on every state entry, so each interval is exactly N*CLK_PER_US cycles.
- States and transitions:
  - IDLE: on trig_s rise, go to TRIG_HI and start measuring the high width in cycles (saturating 16-bit).
  - TRIG_HI: on trig_s fall:
    - If width >= TRIG_MIN_US*CLK_PER_US: latch the echo width W (us) and go to BURST. busy=1 from this cycle.
    - Otherwise: trig_err=1 for one cycle, return to IDLE, busy stays 0.
  - BURST: lasts exactly BURST_US*CLK_PER_US cycles, then go to ECHO with echo=1.
  - ECHO: echo high for exactly W*CLK_PER_US cycles, then echo=0 and go to HOLDOFF.
  - HOLDOFF: lasts HOLDOFF_US*CLK_PER_US cycles, then go to IDLE with busy=0.
- Echo width W:
  - If obj_present=0 or distance_cm > MAX_CM: W = TIMEOUT_US.
  - Otherwise: W = max(distance_cm, 2) * US_PER_CM.
  - Product is computed 16-bit unsigned; max 23200 fits.
- Latency: the first clk edge at which the trig pin is sampled low is edge N. Then:
  - echo rises at edge N + 2 + BURST_US*CLK_PER_US (2 sync + 1 detect, burst counted from the detect cycle).
  - echo falls W*CLK_PER_US cycles after it rises.
- Boundary rules:
  - trig edges in BURST, ECHO or HOLDOFF are ignored entirely (no retrigger, no trig_err).
  - A trig that is still high when HOLDOFF ends is not accepted. A new rise, seen in IDLE, is required.
  - distance_cm and obj_present changes after acceptance do not affect the pulse in flight.
  - trig high exactly TRIG_MIN_US*CLK_PER_US cycles is accepted; one cycle less produces trig_err.
  - Very long trig high: the width counter saturates and the pulse is still accepted on fall.
  - Reset asserted mid-operation: echo and busy drop immediately (async). If trig is high when reset releases, the synchronizer yields a rise and the high width is measured from that point.

Test Plan:
- distance_cm=100, obj_present=1, 12 us trig -> echo rises 2+20000 cycles after trig fall; echo high 580000 cycles (5800 us); busy falls 100000 cycles after echo falls.
- distance_cm=1 -> echo width clamped to 116 us (11600 cycles); distance_cm=401 or obj_present=0 -> echo width 3800000 cycles.
- trig high 999 cycles -> single-cycle trig_err, echo and busy stay 0; trig high 1000 cycles -> accepted, no trig_err.
- Second 12 us trig issued during ECHO and during HOLDOFF -> no change in echo width, no extra pulse; new trig after busy falls -> normal response.
- distance_cm changed 100->300 during BURST -> echo width remains 580000 cycles.
- rst_n pulsed low mid-ECHO -> echo=0 and busy=0 within the same cycle; next valid trig after release produces a normal pulse.
